// File: rtl/jtframe_cen_ctrl.sv
// Fractional CPU clock-enable (rate num/den of clk) with req/ack rate changes at cen boundaries,
// pause/resume and waitn gating. Optional JTFRAME_CEN_RECOVERY_EN replays hits lost to waitn.
module jtframe_cen_ctrl #(
    parameter int W    = 10,
    parameter int NUM0 = 1,
    parameter int DEN0 = 4,
    parameter int MW   = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    input  logic         cfg_req,
    output logic         cfg_ack,
    output logic         cfg_err,
    input  logic         pause_req,
    output logic         paused,
    input  logic         waitn,
    output logic         cen
);

    typedef enum logic {RUN, PAUSED} state_t;

    state_t       state, state_nx;
    logic [W-1:0] num_r, den_r;
    logic [W:0]   acc, acc_nx, sum;
    logic         hit, bad, seen, apply, armed, rec;

    always_comb begin
        state_nx = state;
        case (state)
            RUN:    if (hit && pause_req) state_nx = PAUSED;
            PAUSED: if (!pause_req)       state_nx = RUN;
        endcase
    end

    always_comb begin
        sum   = acc + {1'b0, num_r};
        hit   = (state == RUN) && (sum >= {1'b0, den_r});
        bad   = (den == '0) || (num > den);
        seen  = cfg_req && armed;
        // a valid rate change lands right after a boundary, so no CPU cycle is ever shortened
        apply = seen && !bad && (hit || state == PAUSED);
        acc_nx = acc;
        if (apply)
            acc_nx = '0;
        else if (hit)
            acc_nx = sum - {1'b0, den_r};
        else if (state == RUN)
            acc_nx = sum;
    end

`ifdef JTFRAME_CEN_RECOVERY_EN
    logic [MW-1:0] miss;

    // replayed pulses never follow a cen directly and never collide with a natural hit
    assign rec = (state == RUN) && waitn && (miss != '0) && !hit && !cen;

    always_ff @(posedge clk) begin
        if (rst)
            miss <= '0;
        else if (apply)
            miss <= '0;
        else if (hit && !waitn) begin
            if (miss != '1)
                miss <= miss + 1'b1;
        end else if (rec)
            miss <= miss - 1'b1;
    end
`else
    assign rec = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            num_r   <= W'(NUM0);
            den_r   <= W'(DEN0);
            acc     <= '0;
            cen     <= 1'b0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            armed   <= 1'b1;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            cen     <= (hit && waitn) || rec;
            cfg_ack <= seen && (bad || apply);
            cfg_err <= seen && bad;
            if (apply) begin
                num_r <= num;
                den_r <= den;
            end
            // a held request is served once; it must drop before the next one counts
            if (!cfg_req)
                armed <= 1'b1;
            else if (seen && (bad || apply))
                armed <= 1'b0;
        end
    end

    assign paused = (state == PAUSED);

endmodule

// File: tb/tb_jtframe_cen_ctrl.sv
// Bench for jtframe_cen_ctrl: directed scenarios then random traffic, checked every cycle
// against a model that derives hits from floor(k*num/den) since the last config load.
module tb_jtframe_cen_ctrl;

    localparam int W    = 10;
    localparam int NUM0 = 1;
    localparam int DEN0 = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] num = '0;
    logic [W-1:0] den = '0;
    logic         cfg_req = 1'b0;
    logic         cfg_ack, cfg_err;
    logic         pause_req = 1'b0;
    logic         paused;
    logic         waitn = 1'b1;
    logic         cen;

    jtframe_cen_ctrl #(.W(W), .NUM0(NUM0), .DEN0(DEN0), .MW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .den       (den),
        .cfg_req   (cfg_req),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .pause_req (pause_req),
        .paused    (paused),
        .waitn     (waitn),
        .cen       (cen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad_cnt = 0;
    int cen_cnt = 0;
    int ack_cnt = 0;

    // reference model state
    int m_num, m_den, k, m_miss;
    bit m_paused, m_armed;
    bit exp_cen, exp_ack, exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step();
        bit hit, newreq, badcfg, rec, apply;
        if (rst) begin
            m_num = NUM0; m_den = DEN0; k = 0; m_miss = 0;
            m_paused = 0; m_armed = 1;
            exp_cen = 0; exp_ack = 0; exp_err = 0;
            return;
        end
        badcfg = (den == 0) || (num > den);
        newreq = m_armed && cfg_req;
        hit = 0;
        if (!m_paused) begin
            k++;
            hit = ((k * m_num) / m_den) != (((k - 1) * m_num) / m_den);
        end
        rec = 0;
`ifdef JTFRAME_CEN_RECOVERY_EN
        rec = !m_paused && waitn && (m_miss > 0) && !hit && !exp_cen;
`endif
        apply   = newreq && !badcfg && (m_paused || hit);
        exp_cen = (hit && waitn) || rec;
        exp_ack = newreq && (badcfg || apply);
        exp_err = newreq && badcfg;
        if (apply) begin
            m_num = int'(num); m_den = int'(den); k = 0; m_miss = 0;
        end else if (hit && !waitn)
            m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        else if (rec)
            m_miss--;
        if (!cfg_req)
            m_armed = 1;
        else if (exp_ack)
            m_armed = 0;
        if (m_paused)
            m_paused = pause_req;
        else if (hit && pause_req)
            m_paused = 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("cen", cen, exp_cen);
        check("cfg_ack", cfg_ack, exp_ack);
        check("cfg_err", cfg_err, exp_err);
        check("paused", paused, m_paused);
        if (cen === 1'b1) cen_cnt++;
        if (cfg_ack === 1'b1) ack_cnt++;
    endtask

    task automatic do_cfg(input int n, input int d, output int lat);
        num = 10'(n);
        den = 10'(d);
        cfg_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (cfg_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("cfg_ack_timeout", (lat != 0), 1);
        cfg_req = 1'b0;
        step();
    endtask

    initial begin
        int lat, cnt, exp_wait;
        bit got_ack;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // default rate 1/4
        cen_cnt = 0;
        repeat (1000) step();
        check("rate_1_4_count", cen_cnt, 250);

        // 3/8
        do_cfg(3, 8, lat);
        check("ack_lat_3_8", (lat <= 5), 1);
        for (int w = 0; w < 5; w++) begin
            cen_cnt = 0;
            repeat (8) step();
            check("rate_3_8_window", cen_cnt, 3);
        end

        // back to 1/4, then two invalid requests
        do_cfg(1, 4, lat);
        do_cfg(1, 0, lat);
        check("ack_lat_den0", lat, 1);
        do_cfg(5, 4, lat);
        check("ack_lat_num_gt_den", lat, 1);
        cen_cnt = 0;
        repeat (40) step();
        check("rate_after_invalid", cen_cnt, 10);

        // pause mid-period
        step();
        pause_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (paused === 1'b1) break;
            step();
        end
        check("pause_enter", paused, 1);
        cen_cnt = 0;
        repeat (20) step();
        check("paused_no_cen", cen_cnt, 0);
        do_cfg(1, 2, lat);
        check("ack_lat_paused", lat, 1);
        pause_req = 1'b0;
        repeat (12) step();
        do_cfg(1, 4, lat);

        // waitn low for 8 clocks at 1/4
        cen_cnt = 0;
        repeat (10) step();
        waitn = 1'b0;
        repeat (8) step();
        waitn = 1'b1;
        repeat (22) step();
`ifdef JTFRAME_CEN_RECOVERY_EN
        exp_wait = 10;
`else
        exp_wait = 8;
`endif
        check("waitn_count", cen_cnt, exp_wait);

        // reset with a request in flight, request held through release
        for (int i = 0; i < 10; i++) begin
            if (cen === 1'b1) break;
            step();
        end
        check("cen_before_rst", cen, 1);
        num = 10'd3;
        den = 10'd8;
        cfg_req = 1'b1;
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        ack_cnt = 0;
        repeat (15) step();
        check("ack_once_after_rst", ack_cnt, 1);
        cfg_req = 1'b0;
        repeat (3) step();

        // random traffic
        got_ack = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) pause_req = !pause_req;
            waitn = ($urandom_range(0, 4) != 0);
            if (cfg_req && got_ack && $urandom_range(0, 1) == 0)
                cfg_req = 1'b0;
            else if (!cfg_req && $urandom_range(0, 7) == 0) begin
                num = 10'($urandom_range(1, 13));
                den = 10'($urandom_range(0, 12));
                cfg_req = 1'b1;
                got_ack = 0;
            end
            step();
            if (cfg_ack === 1'b1) got_ack = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
